// File: rtl/dmem_responder.sv
// dmem_responder: word-organised data RAM behind a valid/ready load/store port
//
// Ports:
//   clk, rst          single clock, synchronous active-high reset
//   req_valid_i       request present
//   req_ready_o       high in IDLE, when a request can be accepted
//   req_we_i          1 = store, 0 = load
//   req_size_i        funct3 size: 000 B, 001 H, 010 W, 100 BU, 101 HU
//   req_addr_i        byte address
//   req_wdata_i       right-aligned store data
//   rsp_valid_o       response present (RESP state)
//   rsp_ready_i       core accepts the response
//   rsp_rdata_o       extended load data, 0 for stores and faults
//   rsp_err_o         request faulted
//
// Build option: define DMEM_ERR_CHECK_EN to fault misaligned and
// out-of-range accesses; otherwise low address bits are forced to lane
// alignment and upper bits wrap.
module dmem_responder #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_CYCLES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_we_i,
    input  logic [2:0]  req_size_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);
    localparam int AW = $clog2(DEPTH_WORDS);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_WAIT = 2'd1;
    localparam logic [1:0] S_RESP = 2'd2;
    localparam logic [3:0] CNT_INIT = (WAIT_CYCLES == 0) ? 4'd0 : 4'(WAIT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        we_q;
    logic [2:0]  size_q;
    logic [31:0] addr_q, wdata_q;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic [31:0] mem_q [DEPTH_WORDS];

    logic        accept, fire, wr_en, a_we, size_bad, a_err;
    logic [2:0]  a_size;
    logic [31:0] a_addr, a_wdata, word, ld, wd;
    logic [7:0]  b;
    logic [15:0] h;
    logic [3:0]  be;
    logic [AW-1:0] idx;

    assign req_ready_o = state_q == S_IDLE;
    assign rsp_valid_o = state_q == S_RESP;
    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

    always_comb begin
        accept  = state_q == S_IDLE && req_valid_i;
        // With no wait states the RAM is accessed on the acceptance edge,
        // so the live request fields are used instead of the latched copy.
        fire    = (WAIT_CYCLES == 0) ? accept : (state_q == S_WAIT && cnt_q == 4'd0);
        a_we    = (state_q == S_IDLE) ? req_we_i : we_q;
        a_size  = (state_q == S_IDLE) ? req_size_i : size_q;
        a_addr  = (state_q == S_IDLE) ? req_addr_i : addr_q;
        a_wdata = (state_q == S_IDLE) ? req_wdata_i : wdata_q;
        size_bad = a_size == 3'b011 || a_size[2:1] == 2'b11 || (a_size[2] && a_we);
`ifdef DMEM_ERR_CHECK_EN
        a_err = size_bad
              || (a_size[1:0] == 2'b01 && a_addr[0])
              || (a_size[1:0] == 2'b10 && a_addr[1:0] != 2'b00)
              || (|a_addr[31:AW+2]);
`else
        a_err = size_bad;
`endif
        idx  = a_addr[AW+1:2];
        word = mem_q[idx];
        b    = 8'(word >> {a_addr[1:0], 3'b000});
        h    = a_addr[1] ? word[31:16] : word[15:0];
        // size[2] marks the unsigned variants, which suppresses sign fill
        ld   = (a_size[1:0] == 2'b00) ? {{24{~a_size[2] & b[7]}}, b}
             : (a_size[1:0] == 2'b01) ? {{16{~a_size[2] & h[15]}}, h}
             : word;
        be   = (a_size[1:0] == 2'b00) ? 4'b0001 << a_addr[1:0]
             : (a_size[1:0] == 2'b01) ? (a_addr[1] ? 4'b1100 : 4'b0011)
             : 4'b1111;
        wd   = (a_size[1:0] == 2'b00) ? {4{a_wdata[7:0]}}
             : (a_size[1:0] == 2'b01) ? {2{a_wdata[15:0]}}
             : a_wdata;
        wr_en   = fire && a_we && !a_err && !rst;
        rdata_d = fire ? ((a_we || a_err) ? 32'd0 : ld) : rdata_q;
        err_d   = fire ? a_err : err_q;
        cnt_d   = accept ? CNT_INIT : (state_q == S_WAIT && cnt_q != 4'd0) ? cnt_q - 4'd1 : cnt_q;
        state_d = state_q;
        case (state_q)
            S_IDLE:  state_d = accept ? ((WAIT_CYCLES == 0) ? S_RESP : S_WAIT) : S_IDLE;
            S_WAIT:  state_d = (cnt_q == 4'd0) ? S_RESP : S_WAIT;
            S_RESP:  state_d = rsp_ready_i ? S_IDLE : S_RESP;
            default: state_d = S_IDLE;
        endcase
    end

`ifndef DMEM_ERR_CHECK_EN
    logic unused_addr_hi;
    assign unused_addr_hi = ^a_addr[31:AW+2];
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            we_q    <= req_we_i;
            size_q  <= req_size_i;
            addr_q  <= req_addr_i;
            wdata_q <= req_wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < 4; i++)
            if (wr_en && be[i]) mem_q[idx][8*i +: 8] <= wd[8*i +: 8];
    end
endmodule

// File: tb/tb_dmem_responder.sv
module tb_dmem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst, req_valid, req_we, rsp_ready, req_ready, rsp_valid, rsp_err;
    logic [2:0]  req_size;
    logic [31:0] req_addr, req_wdata, rsp_rdata;
    logic        bb_valid, rdy0, vld0, err0, rdy3, vld3, err3;
    logic [31:0] rd0, rd3;
    int checks = 0, failures = 0, cyc = 0;
    int last0 = -1, last3 = -1, n0 = 0, n3 = 0;

    typedef struct {logic [31:0] rdata; logic err; string name;} exp_t;
    exp_t sb[$];
    exp_t e;

    dmem_responder #(.DEPTH_WORDS(1024), .WAIT_CYCLES(1)) u1 (
        .clk(clk), .rst(rst), .req_valid_i(req_valid), .req_ready_o(req_ready),
        .req_we_i(req_we), .req_size_i(req_size), .req_addr_i(req_addr),
        .req_wdata_i(req_wdata), .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready),
        .rsp_rdata_o(rsp_rdata), .rsp_err_o(rsp_err));

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(0)) u0 (
        .clk(clk), .rst(rst), .req_valid_i(bb_valid), .req_ready_o(rdy0),
        .req_we_i(1'b1), .req_size_i(3'b010), .req_addr_i(32'h10),
        .req_wdata_i(32'hA5A5_0001), .rsp_valid_o(vld0), .rsp_ready_i(1'b1),
        .rsp_rdata_o(rd0), .rsp_err_o(err0));

    dmem_responder #(.DEPTH_WORDS(64), .WAIT_CYCLES(3)) u3 (
        .clk(clk), .rst(rst), .req_valid_i(bb_valid), .req_ready_o(rdy3),
        .req_we_i(1'b1), .req_size_i(3'b010), .req_addr_i(32'h10),
        .req_wdata_i(32'hA5A5_0003), .rsp_valid_o(vld3), .rsp_ready_i(1'b1),
        .rsp_rdata_o(rd3), .rsp_err_o(err3));

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string n, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", n, act, exp);
        end
    endtask

    always @(negedge clk) begin
        if (rsp_valid && rsp_ready) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected response: got %h expected none", rsp_rdata);
            end else begin
                e = sb.pop_front();
                chk({e.name, " rdata"}, rsp_rdata, e.rdata);
                chk({e.name, " err"}, 32'(rsp_err), 32'(e.err));
            end
        end
    end

    always @(negedge clk) begin
        if (bb_valid && vld0) begin
            if (last0 >= 0) chk("spacing w0", 32'(cyc - last0), 32'd2);
            chk("w0 store rdata", rd0, 32'd0);
            last0 <= cyc;
            n0 <= n0 + 1;
        end
        if (bb_valid && vld3) begin
            if (last3 >= 0) chk("spacing w3", 32'(cyc - last3), 32'd5);
            chk("w3 store err", 32'(err3), 32'd0);
            last3 <= cyc;
            n3 <= n3 + 1;
        end
    end

    task automatic issue(input logic we, input logic [2:0] sz, input logic [31:0] a, input logic [31:0] d,
                         input logic [31:0] er, input logic ee, input string n, input bit push);
        int k = 0;
        if (push) sb.push_back('{er, ee, n});
        @(posedge clk) #1;
        req_valid = 1'b1; req_we = we; req_size = sz; req_addr = a; req_wdata = d;
        @(negedge clk);
        while (!req_ready && k < 50) begin
            @(negedge clk);
            k++;
        end
        if (!req_ready) begin
            checks++;
            failures++;
            $display("FAIL accept timeout %s: req_ready got 0 expected 1", n);
        end
        @(posedge clk) #1;
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int k = 0;
        while (sb.size() != 0 && k < 100) begin
            @(negedge clk);
            k++;
        end
        if (sb.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain timeout: pending got %0d expected 0", sb.size());
            sb.delete();
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        rst = 1'b1; req_valid = 1'b1; req_we = 1'b0; req_size = 3'b010;
        req_addr = 32'h0; req_wdata = 32'h0; rsp_ready = 1'b1; bb_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        chk("reset req_ready", 32'(req_ready), 32'd1);
        chk("reset rsp_valid", 32'(rsp_valid), 32'd0);
        chk("reset rsp_rdata", rsp_rdata, 32'd0);
        chk("reset rsp_err", 32'(rsp_err), 32'd0);
        req_valid = 1'b0;

        issue(1, 3'b010, 32'h0, 32'h0, 32'h0, 0, "sw 0x0", 1);
        drain();
        issue(0, 3'b010, 32'h0, 32'h0, 32'h0, 0, "lw 0x0", 1);
        @(negedge clk);
        chk("latency cycle1 rsp_valid", 32'(rsp_valid), 32'd0);
        @(negedge clk);
        chk("latency cycle2 rsp_valid", 32'(rsp_valid), 32'd1);
        drain();

        issue(1, 3'b010, 32'h80, 32'hDEADBEEF, 32'h0, 0, "sw 0x80", 1);
        issue(1, 3'b000, 32'h81, 32'h00000055, 32'h0, 0, "sb 0x81", 1);
        issue(0, 3'b010, 32'h80, 32'h0, 32'hDEAD55EF, 0, "lw 0x80", 1);
        issue(0, 3'b000, 32'h83, 32'h0, 32'hFFFFFFDE, 0, "lb 0x83", 1);
        issue(0, 3'b100, 32'h83, 32'h0, 32'h000000DE, 0, "lbu 0x83", 1);
        issue(0, 3'b001, 32'h82, 32'h0, 32'hFFFFDEAD, 0, "lh 0x82", 1);
        issue(0, 3'b101, 32'h80, 32'h0, 32'h000055EF, 0, "lhu 0x80", 1);
        drain();

        @(posedge clk) #1 rsp_ready = 1'b0;
        issue(0, 3'b010, 32'h80, 32'h0, 32'hDEAD55EF, 0, "stall lw", 1);
        k = 0;
        while (!rsp_valid && k < 20) begin
            @(negedge clk);
            k++;
        end
        chk("stall rsp_valid", 32'(rsp_valid), 32'd1);
        @(posedge clk) #1;
        sb.push_back('{32'h000000EF, 1'b0, "post-stall lbu"});
        req_valid = 1'b1; req_we = 1'b0; req_size = 3'b100; req_addr = 32'h80;
        repeat (5) begin
            @(negedge clk);
            chk("stall rdata", rsp_rdata, 32'hDEAD55EF);
            chk("stall err", 32'(rsp_err), 32'd0);
            chk("stall req_ready", 32'(req_ready), 32'd0);
        end
        @(posedge clk) #1 rsp_ready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("idle after handshake req_ready", 32'(req_ready), 32'd1);
        chk("idle after handshake rsp_valid", 32'(rsp_valid), 32'd0);
        @(posedge clk) #1 req_valid = 1'b0;
        drain();

        issue(1, 3'b010, 32'h40, 32'h0, 32'h0, 0, "sw 0x40 preload", 1);
        drain();
        issue(1, 3'b010, 32'h40, 32'h12345678, 32'h0, 0, "sw dropped", 0);
        rst = 1'b1;
        @(posedge clk) #1 rst = 1'b0;
        repeat (4) begin
            @(negedge clk);
            chk("dropped rsp_valid", 32'(rsp_valid), 32'd0);
        end
        issue(0, 3'b010, 32'h40, 32'h0, 32'h00000000, 0, "lw 0x40 after drop", 1);

        issue(0, 3'b011, 32'h0, 32'h0, 32'h0, 1, "size 011", 1);
        issue(1, 3'b100, 32'h80, 32'hFFFFFFFF, 32'h0, 1, "store size 100", 1);
        issue(0, 3'b010, 32'h80, 32'h0, 32'hDEAD55EF, 0, "lw 0x80 unchanged", 1);
`ifdef DMEM_ERR_CHECK_EN
        issue(1, 3'b001, 32'h41, 32'h0000BEEF, 32'h0, 1, "sh 0x41", 1);
        issue(0, 3'b010, 32'h40, 32'h0, 32'h00000000, 0, "lw 0x40", 1);
        issue(0, 3'b001, 32'h83, 32'h0, 32'h0, 1, "lh 0x83", 1);
        issue(0, 3'b010, 32'h1080, 32'h0, 32'h0, 1, "lw 0x1080", 1);
`else
        issue(1, 3'b001, 32'h41, 32'h0000BEEF, 32'h0, 0, "sh 0x41", 1);
        issue(0, 3'b010, 32'h40, 32'h0, 32'h0000BEEF, 0, "lw 0x40", 1);
        issue(0, 3'b001, 32'h83, 32'h0, 32'hFFFFDEAD, 0, "lh 0x83", 1);
        issue(0, 3'b010, 32'h1080, 32'h0, 32'hDEAD55EF, 0, "lw 0x1080", 1);
`endif
        drain();

        @(posedge clk) #1 bb_valid = 1'b1;
        repeat (30) @(posedge clk);
        #1 bb_valid = 1'b0;
        repeat (8) @(posedge clk);
        chk("w0 response count", 32'(n0 >= 4), 32'd1);
        chk("w3 response count", 32'(n3 >= 4), 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/dmem_responder.md
# dmem_responder

Data-memory responder for the RV32I core: the memory-side end of the load/store interface driven by the decoder's `mem_read`, `mem_write` and `mem_size` controls. It accepts one request at a time over a valid/ready handshake and inserts a configurable number of wait states. Byte-lane steering, store masking and load sign/zero extension for LB/LH/LW/LBU/LHU/SB/SH/SW all happen inside the block, which holds a word-organised RAM. It sits between the core's load/store path and on-chip data storage, and is the platform for moving to a multi-cycle core.

## Interface
- `DEPTH_WORDS`, 1024: RAM depth in 32-bit words; power of two, ≥4.
- `WAIT_CYCLES`, 1: wait states between request acceptance and response; 0..15.
- `clk` input 1: single clock; all state updates on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `req_valid` input 1: request present.
- `req_ready` output 1: block can accept a request.
- `req_we` input 1: 1 = store (`mem_write`), 0 = load (`mem_read`).
- `req_size` input 3: access size in funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU; stores use 000/001/010 only.
- `req_addr` input 32: byte address.
- `req_wdata` input 32: store data, right-aligned (bits [7:0] for SB).
- `rsp_valid` output 1: response present.
- `rsp_ready` input 1: core accepts response.
- `rsp_rdata` output 32: load result, extended to 32 bits; 0 for stores and errors.
- `rsp_err` output 1: request faulted (see Configuration); valid with `rsp_valid`.

## Operation
- FSM states: IDLE, WAIT, RESP.
- IDLE: `req_ready`=1. On `req_valid`: latch we/size/addr/wdata and go to WAIT, or go straight to RESP if `WAIT_CYCLES`=0. Load the wait counter with `WAIT_CYCLES`-1.
- WAIT: `req_ready`=0. Decrement the counter each cycle and go to RESP when it reaches 0.
- RESP: `rsp_valid`=1. Outputs stay stable until `rsp_ready`=1, then return to IDLE. There is no IDLE bypass, so one idle cycle always separates responses.
- Word index is `addr[log2(DEPTH_WORDS)+1:2]`; upper address bits are ignored unless the error check is compiled in.
- Store commit happens on the edge leaving WAIT, or the acceptance edge when `WAIT_CYCLES`=0:
  - SB writes lane `addr[1:0]` with `wdata[7:0]`.
  - SH writes lanes {1,0} or {3,2} per `addr[1]`.
  - SW writes all four lanes.
  - Other lanes are untouched.
- Load data is read on the same edge and registered into `rsp_rdata`:
  - B/H: sign-extend bit 7 or bit 15 of the selected lane(s).
  - BU/HU: zero-extend.
- Invalid `req_size` (011, 11x, or 1xx with `req_we`=1): no write, `rsp_rdata`=0, `rsp_err`=1. This holds regardless of the macro.
- Reset values: state=IDLE, `req_ready`=1 from the first cycle after reset, `rsp_valid`=0, `rsp_rdata`=0, `rsp_err`=0, counter=0.
- RAM contents are not reset.
- Reset in WAIT: the request is dropped and no store commits. Reset in RESP: the response is dropped, but an already-committed store persists.

## Timing
- Request accepted at edge T (`req_valid` & `req_ready`). `rsp_valid` rises after edge T+1+`WAIT_CYCLES`-1, i.e. it is visible in cycle T+`WAIT_CYCLES`+1. With `WAIT_CYCLES`=0, `rsp_valid` is high in the cycle after acceptance.
- Back-to-back throughput: one request per `WAIT_CYCLES`+2 cycles when `rsp_ready` is held at 1.
- A load issued after a store to the same address returns the stored value, since the commit precedes the next acceptance.
- `rsp_ready` held low extends RESP indefinitely; `req_valid` is ignored in that time.

## Configuration
- `DMEM_ERR_CHECK_EN` defined: misalignment (H with `addr[0]`=1; W with `addr[1:0]`≠0) or out-of-range address (`addr` ≥ 4·`DEPTH_WORDS`) sets `rsp_err`=1, suppresses the store and forces `rsp_rdata`=0.
- Not defined: misaligned low bits are forced to lane alignment (H uses `addr[1]` only; W ignores `addr[1:0]`), upper bits wrap modulo the RAM size, and `rsp_err` is set only for invalid `req_size`.

## Test plan
- Reset with `req_valid`=1 → `req_ready`=1 and `rsp_valid`=0 in the first post-reset cycle; a single LW at 0x0 with `WAIT_CYCLES`=1 → `rsp_valid` high exactly 2 cycles after acceptance.
- SW 0x80 = 0xDEADBEEF, SB 0x81 = 0x55, then LW 0x80 → 0xDEAD55EF; LB 0x83 → 0xFFFFFFDE; LBU 0x83 → 0x000000DE; LH 0x82 → 0xFFFFDEAD; LHU 0x80 → 0x000055EF.
- Hold `rsp_ready`=0 for 5 cycles during RESP → `rsp_rdata` and `rsp_err` stable and `req_ready`=0 throughout; new request accepted only after the handshake plus 1 idle cycle.
- `WAIT_CYCLES`=0 and 3: back-to-back requests → response spacing 2 and 5 cycles respectively.
- Assert `rst` while in WAIT on an SW 0x40 = 0x12345678 (pre-loaded 0) → no response; LW 0x40 → 0x00000000.
- With `DMEM_ERR_CHECK_EN`: SH 0x41 → `rsp_err`=1 and memory unchanged. Without it: SH 0x41 = 0xBEEF writes lanes {1,0} and `rsp_err`=0. Either build: size 011 → `rsp_err`=1.
